fir_seq_ctrl: RTL

//  Sequencer in front of the 102-tap pipelined FIR datapath.

---
 rtl/fir_ctrl_pkg.sv | 26 ++
 rtl/fir_valid_tracker.sv | 24 ++
 rtl/fir_seq_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and default sizing for the FIR sequencer.
// Defaults describe the 102-tap pipelined filter it fronts.
package fir_ctrl_pkg;

  localparam int DEF_TAPS      = 102;
  localparam int DEF_LATENCY   = 102;
  localparam int DEF_FLUSH_LEN = 202;
  localparam int DEF_DIN_W     = 16;
  localparam int DEF_COEF_W    = 32;
  localparam int DEF_DOUT_W    = 64;
  localparam int DEF_ADDR_W    = $clog2(DEF_TAPS);

  typedef logic [DEF_ADDR_W-1:0] coef_addr_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SWAP,
    FLUSH
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fir_valid_tracker.sv
// Tag delay line: marks which filter outputs come from real samples.
// Cleared on reset so stale tags never surface.
module fir_valid_tracker #(
  parameter int DEPTH = 102
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tag_in,
  output logic tag_out
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], tag_in};
    end
  end

  assign tag_out = sr[DEPTH-1];

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sample gating, tagging and coefficient-swap sequencing for the FIR.
// Commit runs drain -> swap -> flush so outputs never mix banks.
module fir_seq_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS      = DEF_TAPS,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int FLUSH_LEN = DEF_FLUSH_LEN,
  parameter int DIN_W     = DEF_DIN_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int DOUT_W    = DEF_DOUT_W,
  localparam int AW       = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DIN_W-1:0]  s_data,
  input  logic              cfg_wr,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [COEF_W-1:0] cfg_data,
  input  logic              cfg_commit,
  output logic              cfg_busy,
  output logic              cfg_err,
  output logic [DIN_W-1:0]  fir_din,
  output logic              fir_coef_wr,
  output logic [AW-1:0]     fir_coef_addr,
  output logic [COEF_W-1:0] fir_coef_data,
  output logic              fir_coef_swap,
  input  logic [DOUT_W-1:0] fir_dout,
  output logic              m_valid,
  output logic [DOUT_W-1:0] m_data
);

  localparam int CW = $clog2(max_int(LATENCY, FLUSH_LEN));
  localparam logic [CW-1:0] DRAIN_LD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] FLUSH_LD = CW'(FLUSH_LEN - 1);
  localparam logic [AW:0]   ADDR_LIM = (AW+1)'(TAPS);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          tag_in;
  logic          wr_ok;
  logic          err_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FLUSH;
      cnt   <= FLUSH_LD;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    s_ready       = 1'b0;
    cfg_busy      = 1'b1;
    fir_din       = '0;
    fir_coef_swap = 1'b0;
    unique case (state)
      RUN: begin
        s_ready  = 1'b1;
        cfg_busy = 1'b0;
        if (s_valid) fir_din = s_data;
        if (cfg_commit) begin
          state_nx = DRAIN;
          cnt_nx   = DRAIN_LD;
        end
      end
      DRAIN: begin
        if (cnt == '0) state_nx = SWAP;
        else           cnt_nx   = cnt - 1'b1;
      end
      SWAP: begin
        fir_coef_swap = 1'b1;
        state_nx      = FLUSH;
        cnt_nx        = FLUSH_LD;
      end
      FLUSH: begin
        if (cnt == '0) state_nx = RUN;
        else           cnt_nx   = cnt - 1'b1;
      end
    endcase
  end

  assign tag_in = s_valid & s_ready;

  // Writes are never allowed to race the bank swap itself.
  assign wr_ok  = cfg_wr
                & ({1'b0, cfg_addr} < ADDR_LIM)
                & (state != SWAP);
  assign err_nx = (cfg_wr & ~wr_ok)
                | (cfg_commit & (state != RUN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_coef_wr   <= 1'b0;
      fir_coef_addr <= '0;
      fir_coef_data <= '0;
      cfg_err       <= 1'b0;
    end else begin
      fir_coef_wr <= wr_ok;
      cfg_err     <= err_nx;
      if (wr_ok) begin
        fir_coef_addr <= cfg_addr;
        fir_coef_data <= cfg_data;
      end
    end
  end

  fir_valid_tracker #(
    .DEPTH(LATENCY)
  ) u_trk (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .tag_out(m_valid)
  );

  assign m_data = fir_dout;

endmodule
